// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - BCD SS.cc stopwatch feeding the 4-digit 7-segment display driver
module bcd_stopwatch #(
   parameter int TICK_DIV = 500000,
   parameter int SCAN_DIV = 25000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        Start_Stop,
   input  logic        Clear,
   input  logic        Lap,
   output logic [15:0] Result,
   output logic        Running,
   output logic        Overflow,
   output logic        Scan
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2,
      FULL = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_sync1;
   logic [2:0]      r_sync2;
   logic [2:0]      r_prev;
   logic [2:0]      w_edge;
   logic            w_start;
   logic            w_clear;
   logic            w_lap;
   logic [PW-1:0]   r_presc;
   logic [PW-1:0]   w_presc_nxt;
   logic            w_tick;
   logic [15:0]     r_count;
   logic [15:0]     w_count_nxt;
   logic [15:0]     r_snap;
   logic [15:0]     w_snap_nxt;
   logic            r_freeze;
   logic            w_freeze_nxt;
   logic [15:0]     r_result;
   logic            r_running;
   logic            r_overflow;
   logic [SW-1:0]   r_scan_cnt;
   logic            r_scan;

   // Ripple-carry BCD increment: every digit 9 wraps to 0 and carries on in the same cycle
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] res;
      logic        carry;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[4*i +: 4] >= 4'd9) begin
               res[4*i +: 4] = 4'd0;
            end else begin
               res[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   // Buttons: two-flop synchronizer followed by a previous-value flop for rising-edge detection
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
         r_prev  <= 3'b000;
      end else begin
         r_sync1 <= {Lap, Clear, Start_Stop};
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_edge  = r_sync2 & ~r_prev;
   assign w_start = w_edge[0];
   assign w_clear = w_edge[1];
   assign w_lap   = w_edge[2];
   assign w_tick  = (r_state == RUN) && (r_presc == PW'(TICK_DIV - 1));

   // State, count, prescaler and freeze registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= IDLE;
         r_presc    <= '0;
         r_count    <= 16'h0000;
         r_snap     <= 16'h0000;
         r_freeze   <= 1'b0;
         r_result   <= 16'h0000;
         r_running  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_presc    <= w_presc_nxt;
         r_count    <= w_count_nxt;
         r_snap     <= w_snap_nxt;
         r_freeze   <= w_freeze_nxt;
         r_result   <= w_freeze_nxt ? w_snap_nxt : w_count_nxt;
         r_running  <= (w_state_nxt == RUN);
         r_overflow <= (w_state_nxt == FULL);
      end
   end

   // Next-state logic; within a cycle clear outranks start, which outranks lap
   always_comb begin
      w_state_nxt  = r_state;
      w_presc_nxt  = r_presc;
      w_count_nxt  = r_count;
      w_snap_nxt   = r_snap;
      w_freeze_nxt = r_freeze;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
               w_count_nxt = bcd_inc(r_count);
            end
            if (w_tick && (r_count == 16'h9998)) begin
               w_state_nxt  = FULL;
               w_freeze_nxt = 1'b0;
            end else if (w_start) begin
               w_state_nxt = STOP;
            end else if (w_lap) begin
               w_freeze_nxt = ~r_freeze;
               if (!r_freeze) begin
                  w_snap_nxt = r_count;
               end
            end
         end
         STOP: begin
            if (w_clear) begin
               w_state_nxt  = IDLE;
               w_count_nxt  = 16'h0000;
               w_presc_nxt  = '0;
               w_freeze_nxt = 1'b0;
            end else if (w_start) begin
               w_state_nxt = RUN;
            end else if (w_lap) begin
               w_freeze_nxt = 1'b0;
            end
         end
         FULL: begin
            if (w_clear) begin
               w_state_nxt  = IDLE;
               w_count_nxt  = 16'h0000;
               w_presc_nxt  = '0;
               w_freeze_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Free-running digit-select square wave, toggled every SCAN_DIV cycles
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_scan_cnt <= '0;
         r_scan     <= 1'b0;
      end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
         r_scan_cnt <= '0;
         r_scan     <= ~r_scan;
      end else begin
         r_scan_cnt <= r_scan_cnt + SW'(1);
      end
   end

   assign Result   = r_result;
   assign Running  = r_running;
   assign Overflow = r_overflow;
   assign Scan     = r_scan;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - directed self-checking bench for bcd_stopwatch
module tb_bcd_stopwatch;

   logic        CLK;
   logic        RST_N;
   logic        Start_Stop;
   logic        Clear;
   logic        Lap;
   logic [15:0] Result;
   logic        Running;
   logic        Overflow;
   logic        Scan;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc;

   bcd_stopwatch #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .Start_Stop(Start_Stop),
      .Clear     (Clear),
      .Lap       (Lap),
      .Result    (Result),
      .Running   (Running),
      .Overflow  (Overflow),
      .Scan      (Scan)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Edges since reset release; Scan after n edges equals bit 1 of n
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Button pulse: effect of the rising edge is visible after the third clock edge
   task automatic pulse(input logic s, input logic c, input logic l);
      Start_Stop = s;
      Clear      = c;
      Lap        = l;
      step(1);
      Start_Stop = 1'b0;
      Clear      = 1'b0;
      Lap        = 1'b0;
      step(2);
   endtask

   task automatic check_scan(input string tag);
      logic [31:0] c;
      c = 32'(cyc);
      check(tag, {15'd0, Scan}, {15'd0, c[1]});
   endtask

   initial begin
      Start_Stop = 1'b0;
      Clear      = 1'b0;
      Lap        = 1'b0;
      RST_N      = 1'b0;
      step(2);
      check("rst_result",   Result,            16'h0000);
      check("rst_running",  {15'd0, Running},  16'h0000);
      check("rst_overflow", {15'd0, Overflow}, 16'h0000);
      check("rst_scan",     {15'd0, Scan},     16'h0000);
      RST_N = 1'b1;

      // Scan: period of 4 clocks from reset release
      for (int i = 1; i <= 8; i++) begin
         step(1);
         check("scan_wave", {15'd0, Scan}, {15'd0, 1'(i >> 1)});
      end

      // 1. start, 40 cycles in RUN -> 00.10
      pulse(1'b1, 1'b0, 1'b0);
      check("t1_running", {15'd0, Running}, 16'h0001);
      check("t1_zero",    Result,           16'h0000);
      step(39);
      check("t1_0009", Result, 16'h0009);
      step(1);
      check("t1_0010", Result, 16'h0010);

      // 2. 09.99 -> 10.00 in one tick
      step(3956);
      check("t2_0999", Result, 16'h0999);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("t2_hold0999", Result, 16'h0999);
      end
      step(1);
      check("t2_1000", Result, 16'h1000);

      // 3. run to 99.99, saturate, ignore start, clear
      step(35995);
      check("t3_9998",    Result,           16'h9998);
      check("t3_run9998", {15'd0, Running}, 16'h0001);
      step(1);
      check("t3_9999",    Result,            16'h9999);
      check("t3_ovf",     {15'd0, Overflow}, 16'h0001);
      check("t3_notrun",  {15'd0, Running},  16'h0000);
      check_scan("t3_scan");
      pulse(1'b1, 1'b0, 1'b0);
      step(100);
      check("t3_hold",    Result,            16'h9999);
      check("t3_ovfhold", {15'd0, Overflow}, 16'h0001);
      pulse(1'b0, 1'b1, 1'b0);
      check("t3_clr",     Result,            16'h0000);
      check("t3_clrovf",  {15'd0, Overflow}, 16'h0000);
      check("t3_clrrun",  {15'd0, Running},  16'h0000);

      // 4. pause with prescaler at 2, resume, clear ignored in RUN
      pulse(1'b1, 1'b0, 1'b0);
      step(3);
      Start_Stop = 1'b1;
      step(1);
      Start_Stop = 1'b0;
      step(2);
      check("t4_paused",  Result,           16'h0001);
      check("t4_stopped", {15'd0, Running}, 16'h0000);
      step(50);
      check("t4_hold",    Result,           16'h0001);
      pulse(1'b1, 1'b0, 1'b0);
      check("t4_resumed", {15'd0, Running}, 16'h0001);
      step(1);
      check("t4_notick1", Result,           16'h0001);
      step(1);
      check("t4_tick2",   Result,           16'h0002);
      pulse(1'b0, 1'b1, 1'b0);
      check("t4_clrign",  Result,           16'h0002);
      check("t4_clrrun",  {15'd0, Running}, 16'h0001);
      step(1);
      check("t4_0003",    Result,           16'h0003);

      // 5. lap freeze at 00.12, release shows live count
      step(34);
      pulse(1'b0, 1'b0, 1'b1);
      check("t5_frz",     Result, 16'h0012);
      step(8);
      check("t5_frzhold", Result, 16'h0012);
      pulse(1'b0, 1'b0, 1'b1);
      check("t5_live",    Result, 16'h0015);

      // 6. stop, start+clear together -> IDLE, then async reset mid-run
      pulse(1'b1, 1'b0, 1'b0);
      check("t6_stop",    {15'd0, Running}, 16'h0000);
      check("t6_stopval", Result,           16'h0015);
      pulse(1'b1, 1'b1, 1'b0);
      check("t6_clr",     Result,           16'h0000);
      check("t6_clrrun",  {15'd0, Running}, 16'h0000);
      pulse(1'b1, 1'b0, 1'b0);
      check("t6_idle2run", {15'd0, Running}, 16'h0001);
      step(10);
      check("t6_0002",    Result,           16'h0002);
      check_scan("t6_scan");
      #2;
      RST_N = 1'b0;
      #1;
      check("t6_arst_res",  Result,            16'h0000);
      check("t6_arst_run",  {15'd0, Running},  16'h0000);
      check("t6_arst_ovf",  {15'd0, Overflow}, 16'h0000);
      check("t6_arst_scan", {15'd0, Scan},     16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
